// File: rtl/asy_counter_pkg.sv
// Shared types and default sizes for the asynchronous-counter initiator
// and its helper blocks.
package asy_counter_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      CAPT = 2'd2,
      REL  = 2'd3
   } state_t;

   localparam int DATA_W_DEF      = 4;
   localparam int SYNC_STAGES_DEF = 2;

endpackage

// File: rtl/sync_ff_chain.sv
// N-flop synchroniser for a single asynchronous input, cleared to 0 by the
// asynchronous active-low reset. N must be at least 2.
module sync_ff_chain #(
   parameter int N = 2
) (
   input  logic clk_i,
   input  logic arst_n_i,
   input  logic d_i,
   output logic q_o
);

   logic [N-1:0] r_sync;

   always_ff @(posedge clk_i or negedge arst_n_i) begin
      if (!arst_n_i) begin
         r_sync <= '0;
      end else begin
         r_sync <= {r_sync[N-2:0], d_i};
      end
   end

   assign q_o = r_sync[N-1];

endmodule

// File: rtl/asy_counter_initiator.sv
// Clocked initiator for the asynchronous counter's start/ack bundled-data handshake.
// Optional phase timeout with sticky error flag: define KOLMAN_INIT_TIMEOUT_EN.
module asy_counter_initiator
   import asy_counter_pkg::*;
#(
   parameter int DATA_W      = DATA_W_DEF,
   parameter int SYNC_STAGES = SYNC_STAGES_DEF
`ifdef KOLMAN_INIT_TIMEOUT_EN
   ,
   parameter int TIMEOUT_CYC = 255
`endif
) (
   input  logic              clk_i,
   input  logic              arst_n_i,
   input  logic              req_i,
   input  logic              clr_i,
   output logic              busy_o,
   output logic              valid_o,
   output logic [DATA_W-1:0] data_o,
   output logic              err_o,
   output logic              start_o,
   output logic              clr_n_o,
   input  logic              ack_i,
   input  logic [DATA_W-1:0] dout_i,
   output state_t            dbg_state_o
);

   // Four-phase handshake: start_o rises only while ack is low, stays high
   // until ack is seen high, then falls; the cycle closes when ack returns
   // low. dout_i is valid whenever ack_i is high, so it is sampled only once
   // the synchronised ack has been seen.

   state_t            r_state;
   state_t            w_state_nxt;
   logic              w_ack_s;
   logic              r_start;
   logic              r_clr_n;
   logic              r_valid;
   logic [DATA_W-1:0] r_data;
   logic              w_start_nxt;
   logic              w_clr_n_nxt;
   logic              w_capture;
   logic              w_tmo_req;
   logic              w_tmo_rel;

   sync_ff_chain #(
      .N(SYNC_STAGES)
   ) u_ack_sync (
      .clk_i   (clk_i),
      .arst_n_i(arst_n_i),
      .d_i     (ack_i),
      .q_o     (w_ack_s)
   );

   always_comb begin
      w_state_nxt = r_state;
      w_clr_n_nxt = 1'b1;
      w_capture   = 1'b0;
      case (r_state)
         IDLE: begin
            if (clr_i) begin
               w_clr_n_nxt = 1'b0;
            end else if (req_i && !w_ack_s) begin
               w_state_nxt = REQ;
            end
         end
         REQ: begin
            if (w_ack_s) begin
               w_state_nxt = CAPT;
            end else if (w_tmo_req) begin
               w_state_nxt = REL;
            end
         end
         CAPT: begin
            w_capture   = 1'b1;
            w_state_nxt = REL;
         end
         REL: begin
            if (!w_ack_s || w_tmo_rel) begin
               w_state_nxt = IDLE;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
      w_start_nxt = (w_state_nxt == REQ) || (w_state_nxt == CAPT);
   end

   always_ff @(posedge clk_i or negedge arst_n_i) begin
      if (!arst_n_i) begin
         r_state <= IDLE;
         r_start <= 1'b0;
         r_clr_n <= 1'b1;
         r_valid <= 1'b0;
         r_data  <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_start <= w_start_nxt;
         r_clr_n <= w_clr_n_nxt;
         r_valid <= w_capture;
         if (w_capture) begin
            r_data <= dout_i;
         end
      end
   end

`ifdef KOLMAN_INIT_TIMEOUT_EN
   localparam int               TMO_W    = $clog2(TIMEOUT_CYC + 1);
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

   logic [TMO_W-1:0] r_tmo_cnt;
   logic             r_err;

   // The count equals the number of completed cycles spent in the phase.
   assign w_tmo_req = (r_state == REQ) && !w_ack_s && (r_tmo_cnt == TMO_LAST);
   assign w_tmo_rel = (r_state == REL) &&  w_ack_s && (r_tmo_cnt == TMO_LAST);

   always_ff @(posedge clk_i or negedge arst_n_i) begin
      if (!arst_n_i) begin
         r_tmo_cnt <= '0;
         r_err     <= 1'b0;
      end else begin
         if (w_state_nxt != r_state) begin
            r_tmo_cnt <= '0;
         end else if ((r_state == REQ) || (r_state == REL)) begin
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
         end
         if (w_tmo_req || w_tmo_rel) begin
            r_err <= 1'b1;
         end else if ((r_state == IDLE) && clr_i) begin
            r_err <= 1'b0;
         end
      end
   end

   assign err_o = r_err;
`else
   assign w_tmo_req = 1'b0;
   assign w_tmo_rel = 1'b0;
   assign err_o     = 1'b0;
`endif

   assign busy_o      = (r_state != IDLE);
   assign valid_o     = r_valid;
   assign data_o      = r_data;
   assign start_o     = r_start;
   assign clr_n_o     = r_clr_n;
   assign dbg_state_o = r_state;

endmodule

// File: tb/tb_asy_counter_initiator.sv
// Bench for asy_counter_initiator: behavioural async-counter model with
// jittered ack, a FIFO scoreboard of dout values at ack rise, directed cases.
`timescale 1ns/1ps
module tb_asy_counter_initiator;
   import asy_counter_pkg::*;

   localparam int W = 4;

   logic         clk;
   logic         arst_n_i;
   logic         req_i;
   logic         clr_i;
   logic         busy_o;
   logic         valid_o;
   logic [W-1:0] data_o;
   logic         err_o;
   logic         start_o;
   logic         clr_n_o;
   logic         ack_i;
   logic [W-1:0] dout_i;
   state_t       dbg_state;

   int n_checks = 0;
   int n_errs   = 0;
   int n_valid  = 0;

   logic [W-1:0] exp_q[$];
   logic [W-1:0] feed_q[$];
   int           m_dly   = 0;
   bit           m_jit   = 0;
   bit           m_hold  = 0;
   bit           m_stuck = 0;
   logic         prev_start = 1'b0;
   logic         prev_valid = 1'b0;

   asy_counter_initiator #(
      .DATA_W     (W),
      .SYNC_STAGES(2)
`ifdef KOLMAN_INIT_TIMEOUT_EN
      ,
      .TIMEOUT_CYC(8)
`endif
   ) dut (
      .clk_i      (clk),
      .arst_n_i   (arst_n_i),
      .req_i      (req_i),
      .clr_i      (clr_i),
      .busy_o     (busy_o),
      .valid_o    (valid_o),
      .data_o     (data_o),
      .err_o      (err_o),
      .start_o    (start_o),
      .clr_n_o    (clr_n_o),
      .ack_i      (ack_i),
      .dout_i     (dout_i),
      .dbg_state_o(dbg_state)
   );

   // ---------------- clock ----------------
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- checking ----------------
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_checks++;
      if (got !== want) begin
         n_errs++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, want);
      end
   endtask

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic wait_valid(input int target, input int budget, input string tag);
      int k;
      k = 0;
      while (n_valid < target && k < budget) begin
         step();
         k++;
      end
      chk(tag, n_valid, target);
   endtask

   task automatic wait_idle(input int budget, input string tag);
      int k;
      k = 0;
      while (busy_o && k < budget) begin
         step();
         k++;
      end
      chk(tag, busy_o, 0);
   endtask

   // Asynchronous counter model: answers each start with a new dout and ack
   // after a few cycles plus sub-cycle jitter, releases ack after start falls.
   initial begin
      int           d;
      logic [W-1:0] v;
      ack_i  = 1'b0;
      dout_i = '0;
      forever begin
         @(posedge clk);
         if (start_o && !ack_i && !m_stuck) begin
            d = (m_dly > 0) ? m_dly : $urandom_range(1, 3);
            repeat (d) @(posedge clk);
            #(m_jit ? $urandom_range(1, 8) : 1);
            v = (feed_q.size() > 0) ? feed_q.pop_front() : W'($urandom);
            dout_i = v;
            exp_q.push_back(v);
            #1 ack_i = 1'b1;
            do @(posedge clk); while (start_o || m_hold);
            d = (m_dly > 0) ? m_dly : $urandom_range(1, 3);
            repeat (d) @(posedge clk);
            #(m_jit ? $urandom_range(1, 8) : 1);
            ack_i = 1'b0;
         end
      end
   end

   // Scoreboard/monitor: every valid_o pulse must carry the next dout the
   // counter presented at ack rise; start may only rise while ack is low.
   always @(negedge clk) begin
      if (arst_n_i) begin
         if (valid_o) begin
            n_valid++;
            chk("valid_single_cycle", prev_valid, 0);
            if (exp_q.size() == 0) begin
               chk("valid_without_ack", 1, 0);
            end else begin
               chk("data_o", data_o, exp_q.pop_front());
            end
         end
         if (start_o && !prev_start) begin
            chk("ack_low_at_start_rise", ack_i, 0);
         end
      end
      prev_start = start_o;
      prev_valid = valid_o;
   end

   // ---------------- stimulus ----------------
   initial begin
      int base;
      int k;
      arst_n_i = 1'b0;
      req_i    = 1'b0;
      clr_i    = 1'b0;
      repeat (3) step();

      chk("rst_busy", busy_o, 0);
      chk("rst_valid", valid_o, 0);
      chk("rst_data", data_o, 0);
      chk("rst_err", err_o, 0);
      chk("rst_start", start_o, 0);
      chk("rst_clr_n", clr_n_o, 1);
      arst_n_i = 1'b1;
      repeat (3) step();

      // single request, dout 5
      m_dly = 3;
      feed_q.push_back(4'h5);
      base = n_valid;
      req_i = 1'b1;
      step();
      chk("t1_start_rise", start_o, 1);
      req_i = 1'b0;
      wait_valid(base + 1, 40, "t1_valid");
      chk("t1_data", data_o, 4'h5);
      wait_idle(40, "t1_idle");
      chk("t1_start_low", start_o, 0);
      chk("t1_one_valid", n_valid - base, 1);
      step();

      // req held, three back-to-back handshakes
      m_dly = 1;
      feed_q.push_back(4'h1);
      feed_q.push_back(4'h2);
      feed_q.push_back(4'h3);
      base = n_valid;
      req_i = 1'b1;
      wait_valid(base + 3, 200, "t2_three_valid");
      req_i = 1'b0;
      chk("t2_last_data", data_o, 4'h3);
      wait_idle(40, "t2_idle");
      step();

      // clr and req together in IDLE
      m_dly = 2;
      feed_q.push_back(4'h9);
      base = n_valid;
      clr_i = 1'b1;
      req_i = 1'b1;
      step();
      chk("t3_clr_low", clr_n_o, 0);
      chk("t3_no_start", start_o, 0);
      clr_i = 1'b0;
      step();
      chk("t3_clr_one_cycle", clr_n_o, 1);
      chk("t3_start_next", start_o, 1);
      req_i = 1'b0;
      wait_valid(base + 1, 40, "t3_valid");
      chk("t3_data", data_o, 4'h9);
      wait_idle(40, "t3_idle");
      step();

      // reset during REL with ack still high
      m_hold = 1'b1;
      feed_q.push_back(4'hA);
      base = n_valid;
      req_i = 1'b1;
      step();
      req_i = 1'b0;
      wait_valid(base + 1, 40, "t4_valid");
      step();
      chk("t4_busy_in_rel", busy_o, 1);
      #2 arst_n_i = 1'b0;
      #1;
      chk("t4_async_busy", busy_o, 0);
      chk("t4_async_start", start_o, 0);
      chk("t4_async_clr_n", clr_n_o, 1);
      chk("t4_async_valid", valid_o, 0);
      chk("t4_async_data", data_o, 0);
      chk("t4_async_err", err_o, 0);
      step();
      arst_n_i = 1'b1;
      repeat (4) step();
      req_i = 1'b1;
      for (int i = 0; i < 6; i++) begin
         step();
         chk("t4_blocked_by_ack", start_o, 0);
      end
      m_hold = 1'b0;
      k = 0;
      while (!start_o && k < 20) begin
         step();
         k++;
      end
      chk("t4_start_after_ack_low", start_o, 1);
      req_i = 1'b0;
      wait_valid(n_valid + 1, 40, "t4_valid_after");
      wait_idle(40, "t4_idle");
      step();

`ifdef KOLMAN_INIT_TIMEOUT_EN
      // ack stuck low: REQ phase times out
      m_stuck = 1'b1;
      base = n_valid;
      req_i = 1'b1;
      step();
      req_i = 1'b0;
      chk("t5_start", start_o, 1);
      k = 1;
      while (start_o && k < 40) begin
         step();
         k++;
      end
      chk("t5_req_cycles", k, 8);
      chk("t5_err_set", err_o, 1);
      wait_idle(20, "t5_idle");
      chk("t5_err_sticky", err_o, 1);
      chk("t5_no_valid", n_valid - base, 0);
      clr_i = 1'b1;
      step();
      clr_i = 1'b0;
      chk("t5_err_cleared", err_o, 0);
      m_stuck = 1'b0;
      step();
`endif

      // randomized requests with jittered ack
      m_dly = 0;
      m_jit = 1'b1;
      base  = n_valid;
      k     = 0;
      while (n_valid < base + 100 && k < 6000) begin
         req_i = ($urandom_range(0, 3) != 0);
         clr_i = ($urandom_range(0, 15) == 0);
         step();
         k++;
      end
      req_i = 1'b0;
      clr_i = 1'b0;
      chk("t6_handshake_count", (n_valid >= base + 100), 1);
      wait_idle(80, "t6_idle");
      chk("t6_scoreboard_drained", exp_q.size(), 0);
      chk("t6_err_clear", err_o, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_errs);
      $finish;
   end

endmodule
